// File: rtl/operand_pair_stager.sv
// Collects two operand bytes, presents them to an external 8-bit adder, and
// registers the 9-bit sum for a valid/ready consumer; counts consumed results.
module operand_pair_stager #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [8:0]       add_sum,
    output logic             out_valid,
    output logic [8:0]       out_sum,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pair_count,
    output logic [1:0]       state_dbg
);

    // Handshake: a byte moves on in_valid && in_ready, a result moves on
    // out_valid && out_ready; neither valid waits on its ready, and out_valid
    // plus out_sum hold steady until the result is taken.
    typedef enum logic [1:0] {
        A_WAIT = 2'd0,
        B_WAIT = 2'd1,
        CALC   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [8:0] sum_reg;
    logic       in_fire;
    logic       out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= A_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            A_WAIT:  if (in_fire) state_nxt = in_last ? CALC : B_WAIT;
            B_WAIT:  if (in_fire) state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = A_WAIT;
            default: state_nxt = A_WAIT;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            A_WAIT:  in_ready  = 1'b1;
            B_WAIT:  in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // A lone final byte pairs with zero so the adder passes it through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            pair_count <= '0;
        end else begin
            if (state == A_WAIT && in_fire) begin
                a_reg <= in_data;
                if (in_last) b_reg <= '0;
            end
            if (state == B_WAIT && in_fire) b_reg <= in_data;
            if (state == CALC) sum_reg <= add_sum;
            if (out_fire) pair_count <= pair_count + 1'b1;
        end
    end

    assign add_a     = a_reg;
    assign add_b     = b_reg;
    assign out_sum   = sum_reg;
    assign state_dbg = state;

endmodule

// File: doc/operand_pair_stager.md
OPERAND_PAIR_STAGER -- requirements
Module: operand_pair_stager

Interface
REQ-001 Parameter: CNT_W, 8, width of the completed-pair counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 in_valid  input  1  upstream byte present.
REQ-005 in_data  input  8  upstream operand byte.
REQ-006 in_last  input  1  qualifies in_data as the final byte of a stream; meaningful only with in_valid.
REQ-007 in_ready  output  1  stager accepts a byte this cycle.
REQ-008 add_a  output  8  operand A, driven to the downstream 8-bit prefix adder's a input.
REQ-009 add_b  output  8  operand B, driven to the adder's b input.
REQ-010 add_sum  input  9  adder's combinational 9-bit sum of add_a and add_b.
REQ-011 out_valid  output  1  registered result available.
REQ-012 out_sum  output  9  registered sum; bit 8 is carry-out.
REQ-013 out_ready  input  1  downstream consumer accepts the result.
REQ-014 pair_count  output  CNT_W  number of results consumed since reset, modulo 2^CNT_W.

Function
REQ-015 The stager SHALL implement a 4-state FSM: A_WAIT, B_WAIT, CALC, OUT.
REQ-016 A_WAIT: in_ready=1; on in_valid, a_reg<=in_data; if in_last=0, go to B_WAIT; if in_last=1, b_reg<=0 and go to CALC.
REQ-017 B_WAIT: in_ready=1; on in_valid, b_reg<=in_data and go to CALC; in_last in this state has no extra effect.
REQ-018 CALC: in_ready=0; sum_reg<=add_sum; go to OUT unconditionally; one cycle exactly.
REQ-019 OUT: in_ready=0, out_valid=1; on out_ready, pair_count increments and the FSM goes to A_WAIT; otherwise it holds.
REQ-020 add_a SHALL equal a_reg and add_b SHALL equal b_reg at all times, with no combinational path from in_data.
REQ-021 out_sum SHALL equal sum_reg, stable for the whole OUT state; out_valid is 1 only in OUT.
REQ-022 A byte is transferred only when in_valid and in_ready are both 1; in_valid without in_ready SHALL NOT change state.
REQ-023 Latency SHALL be exactly 2 cycles from the B byte's accept edge to out_valid=1: CALC on cycle +1, OUT on cycle +2.
REQ-024 Throughput: at most one result per 4 cycles with continuous in_valid/out_ready; no bubble is inserted beyond the FSM.
REQ-025 pair_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-026 out_valid SHALL NOT drop once asserted until out_ready; out_sum SHALL NOT change while out_valid=1 and out_ready=0.
REQ-027 Arithmetic is unsigned; the stager SHALL NOT alter add_sum; carry appears only in out_sum[8].

Reset
REQ-028 While rst_n=0 at a rising edge: state<=A_WAIT, a_reg<=0, b_reg<=0, sum_reg<=0, pair_count<=0.
REQ-029 Post-reset outputs: in_ready=1, out_valid=0, out_sum=0, add_a=0, add_b=0, pair_count=0.
REQ-030 Reset in any state, including mid-pair (B_WAIT) or OUT with out_ready=0, SHALL discard the partial pair or pending result with no output handshake.
REQ-031 in_valid during reset SHALL be ignored; the first byte is accepted only on an edge with rst_n=1.

Verification
REQ-032 Bytes 0x05, 0x03 with out_ready=1 -> out_valid on cycle +2 after the second accept, out_sum=0x008, pair_count 0->1.
REQ-033 Bytes 0xFF, 0xFF -> out_sum=0x1FE, carry bit 1; bytes 0x80, 0x80 -> out_sum=0x100.
REQ-034 Byte 0x7A with in_last=1 in A_WAIT -> add_b=0, out_sum=0x07A, no B byte consumed.
REQ-035 out_ready held 0 for 10 cycles in OUT, in_valid=1 throughout -> in_ready=0, out_sum stable, no byte lost; release -> next byte accepted as A.
REQ-036 rst_n=0 for one edge while in B_WAIT after 0x11 -> A_WAIT, then 0x22, 0x33 -> out_sum=0x055.
REQ-037 CNT_W=2, 5 consumed results -> pair_count sequence 1,2,3,0,1.
